// File: rtl/reconstruccion.sv
// Frame reconstruction: fills a window of the local frame RAM from the image FIFO,
// then applies motion vectors (RAM[ref] -> RAM[act]) popped from the vector FIFO.
module reconstruccion #(
    parameter int unsigned MSBI = 10,
    parameter int unsigned PX_W = 24
) (
    input  logic                  clk_fsm,
    input  logic                  rst,
    input  logic                  start,
    output logic                  finish,
    output logic                  idle,
    input  logic [1:0]            cont_img,
    input  logic [MSBI:0]         window_limit,
    input  logic                  src_finish,
    input  logic                  img_fifo_empty,
    input  logic [PX_W+1:0]       img_fifo_data,
    output logic                  img_rd_req,
    input  logic                  vector_fifo_empty,
    input  logic [2*MSBI+3:0]     vector_fifo_data,
    output logic                  vector_rd_req,
    output logic [MSBI:0]         add_read,
    input  logic [PX_W-1:0]       data_rd,
    output logic [MSBI:0]         add_write,
    output logic [PX_W-1:0]       data_wr,
    output logic                  wr_enable,
    output logic [MSBI:0]         vec_count,
    output logic                  err_tag,
    output logic                  err_range,
    output logic [2:0]            real_state
);

    localparam int unsigned AW = MSBI + 1;
    localparam int unsigned VW = 2 * MSBI + 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        IMG_WAIT  = 3'd1,
        IMG_POP   = 3'd2,
        VEC_WAIT  = 3'd3,
        VEC_POP   = 3'd4,
        VEC_LAT   = 3'd5,
        VEC_WRITE = 3'd6,
        FINISH    = 3'd7
    } state_t;

    state_t          state;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   ref_q;
    logic [AW-1:0]   act_q;
    logic            src_done;

    // Head-of-FIFO field decode
    logic [1:0]      img_tag;
    logic [PX_W-1:0] img_px;
    logic [1:0]      vec_tag;
    logic [AW-1:0]   vec_ref;
    logic [AW-1:0]   vec_act;
    logic            img_tag_ok;
    logic            vec_tag_ok;
    logic            vec_in_range;

    assign img_tag      = img_fifo_data[PX_W+1:PX_W];
    assign img_px       = img_fifo_data[PX_W-1:0];
    assign vec_tag      = vector_fifo_data[VW-1:VW-2];
    assign vec_ref      = vector_fifo_data[2*AW-1:AW];
    assign vec_act      = vector_fifo_data[AW-1:0];
    assign img_tag_ok   = (img_tag == cont_img);
    assign vec_tag_ok   = (vec_tag == cont_img);
    assign vec_in_range = (vec_ref < window_limit) && (vec_act < window_limit);

    always_ff @(posedge clk_fsm) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            vec_count <= '0;
            err_tag   <= 1'b0;
            err_range <= 1'b0;
            src_done  <= 1'b0;
            ref_q     <= '0;
            act_q     <= '0;
        end else begin
            // End-of-vectors notice may arrive at any point of a run
            if (state != IDLE && src_finish) begin
                src_done <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt       <= '0;
                        vec_count <= '0;
                        err_tag   <= 1'b0;
                        err_range <= 1'b0;
                        src_done  <= src_finish;
                        state     <= IMG_WAIT;
                    end
                end
                IMG_WAIT: begin
                    if (cnt >= window_limit) begin
                        state <= VEC_WAIT;
                    end else if (!img_fifo_empty) begin
                        state <= IMG_POP;
                    end
                end
                IMG_POP: begin
                    if (img_tag_ok) begin
                        cnt <= cnt + AW'(1);
                    end else begin
                        err_tag <= 1'b1;
                    end
                    state <= IMG_WAIT;
                end
                VEC_WAIT: begin
                    if (!vector_fifo_empty) begin
                        state <= VEC_POP;
                    end else if (src_done) begin
                        state <= FINISH;
                    end
                end
                VEC_POP: begin
                    ref_q <= vec_ref;
                    act_q <= vec_act;
                    if (!vec_tag_ok) begin
                        err_tag <= 1'b1;
                        state   <= VEC_WAIT;
                    end else if (!vec_in_range) begin
                        err_range <= 1'b1;
                        state     <= VEC_WAIT;
                    end else begin
                        state <= VEC_LAT;
                    end
                end
                VEC_LAT: begin
                    state <= VEC_WRITE;
                end
                VEC_WRITE: begin
                    if (vec_count != {AW{1'b1}}) begin
                        vec_count <= vec_count + AW'(1);
                    end
                    state <= VEC_WAIT;
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes decoded from state; forced quiet while reset is asserted
    always_comb begin
        finish        = 1'b0;
        idle          = 1'b0;
        img_rd_req    = 1'b0;
        vector_rd_req = 1'b0;
        wr_enable     = 1'b0;
        add_read      = ref_q;
        add_write     = cnt;
        data_wr       = img_px;
        case (state)
            IDLE: idle = 1'b1;
            IMG_POP: begin
                img_rd_req = 1'b1;
                wr_enable  = img_tag_ok;
            end
            VEC_POP: begin
                vector_rd_req = 1'b1;
                add_read      = vec_ref;
            end
            VEC_WRITE: begin
                wr_enable = 1'b1;
                add_write = act_q;
                data_wr   = data_rd;
            end
            FINISH: finish = 1'b1;
            default: begin
            end
        endcase
        if (rst) begin
            finish        = 1'b0;
            img_rd_req    = 1'b0;
            vector_rd_req = 1'b0;
            wr_enable     = 1'b0;
            idle          = 1'b1;
        end
    end

    assign real_state = state;

endmodule

// File: tb/tb_reconstruccion.sv
// Scoreboard bench for reconstruccion: FIFO and registered-RAM models around the DUT,
// expected RAM writes and finish summaries are queued and checked by a monitor.
module tb_reconstruccion;

    logic        clk_fsm = 1'b0;
    logic        rst;
    logic        start;
    logic        finish;
    logic        idle;
    logic [1:0]  cont_img;
    logic [10:0] window_limit;
    logic        src_finish;
    logic        img_fifo_empty;
    logic [25:0] img_fifo_data;
    logic        img_rd_req;
    logic        vector_fifo_empty;
    logic [23:0] vector_fifo_data;
    logic        vector_rd_req;
    logic [10:0] add_read;
    logic [23:0] data_rd;
    logic [10:0] add_write;
    logic [23:0] data_wr;
    logic        wr_enable;
    logic [10:0] vec_count;
    logic        err_tag;
    logic        err_range;
    logic [2:0]  real_state;

    reconstruccion dut (
        .clk_fsm(clk_fsm), .rst(rst), .start(start), .finish(finish), .idle(idle),
        .cont_img(cont_img), .window_limit(window_limit), .src_finish(src_finish),
        .img_fifo_empty(img_fifo_empty), .img_fifo_data(img_fifo_data), .img_rd_req(img_rd_req),
        .vector_fifo_empty(vector_fifo_empty), .vector_fifo_data(vector_fifo_data),
        .vector_rd_req(vector_rd_req), .add_read(add_read), .data_rd(data_rd),
        .add_write(add_write), .data_wr(data_wr), .wr_enable(wr_enable),
        .vec_count(vec_count), .err_tag(err_tag), .err_range(err_range), .real_state(real_state)
    );

    always #5 clk_fsm = ~clk_fsm;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Show-ahead FIFO models; read pointers advance on the DUT pop strobes
    logic [25:0] img_mem [64];
    logic [23:0] vec_mem [64];
    int img_wp = 0, img_rp = 0, vec_wp = 0, vec_rp = 0;
    assign img_fifo_empty    = (img_rp == img_wp);
    assign img_fifo_data     = img_mem[img_rp];
    assign vector_fifo_empty = (vec_rp == vec_wp);
    assign vector_fifo_data  = vec_mem[vec_rp];

    always @(posedge clk_fsm) begin
        if (img_rd_req)    img_rp <= img_rp + 1;
        if (vector_rd_req) vec_rp <= vec_rp + 1;
    end

    // Registered frame RAM
    logic [23:0] ram [2048];
    always @(posedge clk_fsm) begin
        if (wr_enable) ram[add_write] <= data_wr;
        data_rd <= ram[add_read];
    end

    int img_pops = 0;
    always @(negedge clk_fsm) if (img_rd_req) img_pops++;

    typedef struct {
        bit          fin;
        logic [10:0] addr;
        logic [23:0] data;
        logic [10:0] vc;
        bit          et;
        bit          er;
    } exp_t;
    exp_t sb[$];

    // Monitor: every RAM write and every finish pulse consumes one expectation
    always @(negedge clk_fsm) begin
        exp_t e;
        if (wr_enable) begin
            if (sb.size() == 0) chk("unexpected_write", 32'(add_write), 32'hFFFF_FFFF);
            else begin
                e = sb.pop_front();
                chk("wr_kind", 32'(e.fin), 32'(0));
                chk("wr_addr", 32'(add_write), 32'(e.addr));
                chk("wr_data", 32'(data_wr), 32'(e.data));
            end
        end
        if (finish) begin
            if (sb.size() == 0) chk("unexpected_finish", 32'(1), 32'(0));
            else begin
                e = sb.pop_front();
                chk("fin_kind", 32'(e.fin), 32'(1));
                chk("fin_vec_count", 32'(vec_count), 32'(e.vc));
                chk("fin_err_tag", 32'(err_tag), 32'(e.et));
                chk("fin_err_range", 32'(err_range), 32'(e.er));
            end
        end
    end

    task automatic tick();
        @(posedge clk_fsm);
        #1;
    endtask

    task automatic push_img(input logic [1:0] tag, input logic [23:0] px);
        img_mem[img_wp] = {tag, px};
        img_wp++;
    endtask

    task automatic push_vec(input logic [1:0] tag, input logic [10:0] r, input logic [10:0] a);
        vec_mem[vec_wp] = {tag, r, a};
        vec_wp++;
    endtask

    task automatic exp_wr(input logic [10:0] addr, input logic [23:0] data);
        sb.push_back('{fin: 1'b0, addr: addr, data: data, vc: 11'd0, et: 1'b0, er: 1'b0});
    endtask

    task automatic exp_fin(input logic [10:0] vc, input bit et, input bit er);
        sb.push_back('{fin: 1'b1, addr: 11'd0, data: 24'd0, vc: vc, et: et, er: er});
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_src();
        src_finish = 1'b1;
        tick();
        src_finish = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 300 && !idle; n++) tick();
        chk(name, 32'(idle), 32'(1));
    endtask

    int pops0;

    initial begin
        for (int i = 0; i < 64; i++) begin
            img_mem[i] = '0;
            vec_mem[i] = '0;
        end
        for (int i = 0; i < 2048; i++) ram[i] = '0;
        rst = 1'b1; start = 1'b0; src_finish = 1'b0; cont_img = 2'd2; window_limit = 11'd4;
        tick(); tick();
        chk("rst_idle", 32'(idle), 32'(1));
        chk("rst_strobes", 32'({finish, img_rd_req, vector_rd_req, wr_enable}), 32'(0));
        rst = 1'b0;
        tick();
        chk("rst_state", 32'(real_state), 32'(0));
        chk("rst_regs", 32'({vec_count, err_tag, err_range}), 32'(0));

        // Basic run
        window_limit = 11'd4;
        push_img(2, 24'h11); push_img(2, 24'h22); push_img(2, 24'h33); push_img(2, 24'h44);
        push_vec(2, 11'd1, 11'd3);
        exp_wr(0, 24'h11); exp_wr(1, 24'h22); exp_wr(2, 24'h33); exp_wr(3, 24'h44);
        exp_wr(3, 24'h22); exp_fin(1, 0, 0);
        do_start();
        pulse_src();
        wait_idle("basic_done");
        chk("basic_ram", 32'(ram[3]), 32'h22);
        chk("basic_ram0", 32'(ram[0]), 32'h11);
        chk("basic_vc", 32'(vec_count), 32'(1));

        // Image tag mismatch
        window_limit = 11'd2;
        pops0 = img_pops;
        push_img(2, 24'hA0A0A0); push_img(1, 24'hB0B0B0); push_img(2, 24'hC0C0C0);
        exp_wr(0, 24'hA0A0A0); exp_wr(1, 24'hC0C0C0); exp_fin(0, 1, 0);
        do_start();
        pulse_src();
        wait_idle("tagerr_done");
        chk("tagerr_pops", 32'(img_pops - pops0), 32'(3));
        chk("tagerr_ram1", 32'(ram[1]), 32'hC0C0C0);
        chk("tagerr_flag", 32'(err_tag), 32'(1));

        // Range error
        window_limit = 11'd4;
        push_img(2, 24'h101); push_img(2, 24'h202); push_img(2, 24'h303); push_img(2, 24'h404);
        push_vec(2, 11'd5, 11'd0);
        exp_wr(0, 24'h101); exp_wr(1, 24'h202); exp_wr(2, 24'h303); exp_wr(3, 24'h404);
        exp_fin(0, 0, 1);
        do_start();
        pulse_src();
        wait_idle("range_done");
        chk("range_ram0", 32'(ram[0]), 32'h101);
        chk("range_flag", 32'(err_range), 32'(1));

        // Ordering: later vector sees earlier copy
        window_limit = 11'd3;
        push_img(2, 24'hAAAAAA); push_img(2, 24'hBBBBBB); push_img(2, 24'hCCCCCC);
        push_vec(2, 11'd0, 11'd1); push_vec(2, 11'd1, 11'd2);
        exp_wr(0, 24'hAAAAAA); exp_wr(1, 24'hBBBBBB); exp_wr(2, 24'hCCCCCC);
        exp_wr(1, 24'hAAAAAA); exp_wr(2, 24'hAAAAAA); exp_fin(2, 0, 0);
        do_start();
        pulse_src();
        wait_idle("order_done");
        chk("order_ram1", 32'(ram[1]), 32'hAAAAAA);
        chk("order_ram2", 32'(ram[2]), 32'hAAAAAA);

        // src_finish early, data pushed afterwards
        window_limit = 11'd2;
        exp_wr(0, 24'h123456); exp_wr(1, 24'h654321); exp_wr(1, 24'h123456); exp_fin(1, 0, 0);
        do_start();
        tick(); tick();
        chk("early_in_img_wait", 32'(real_state), 32'(1));
        pulse_src();
        tick(); tick(); tick();
        push_vec(2, 11'd0, 11'd1);
        push_img(2, 24'h123456); push_img(2, 24'h654321);
        wait_idle("early_done");

        // Empty window, src_finish in start cycle: finish one cycle after VEC_WAIT
        window_limit = 11'd0;
        exp_fin(0, 0, 0);
        start = 1'b1; src_finish = 1'b1;
        tick();
        start = 1'b0; src_finish = 1'b0;
        chk("empty_s1", 32'(real_state), 32'(1));
        tick();
        chk("empty_s3", 32'(real_state), 32'(3));
        tick();
        chk("empty_fin", 32'({real_state, finish}), 32'({3'd7, 1'b1}));
        tick();
        chk("empty_idle", 32'(idle), 32'(1));

        // Reset during VEC_LAT aborts the copy
        window_limit = 11'd2;
        push_img(2, 24'h0F0F0F); push_img(2, 24'hF0F0F0);
        push_vec(2, 11'd0, 11'd1);
        exp_wr(0, 24'h0F0F0F); exp_wr(1, 24'hF0F0F0);
        do_start();
        for (int n = 0; n < 100 && real_state != 3'd5; n++) tick();
        chk("abort_reach_lat", 32'(real_state), 32'(5));
        rst = 1'b1;
        tick();
        chk("abort_idle", 32'(idle), 32'(1));
        chk("abort_nowr", 32'(wr_enable), 32'(0));
        chk("abort_vc", 32'(vec_count), 32'(0));
        rst = 1'b0;
        tick();
        chk("abort_ram1", 32'(ram[1]), 32'hF0F0F0);

        // start outside IDLE is ignored (would otherwise clear err_tag)
        window_limit = 11'd4;
        push_img(1, 24'hDEAD00);
        do_start();
        tick(); tick(); tick(); tick();
        chk("ign_errtag", 32'(err_tag), 32'(1));
        do_start();
        chk("ign_errtag_kept", 32'(err_tag), 32'(1));
        chk("ign_state", 32'(real_state), 32'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        chk("sb_drained", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
